rv32i_instr_encoder: RTL and testbench

Encodes decoded-form instruction fields (class, registers, funct3, immediate) into 32-bit RV32I instruction words. Writes each word sequentially into instruction memory over a write/ack port. It is the encode side of the opcode/control decode path. Board builds use it to load test programs into imem without an external assembler. Supported classes match the main decoder: R, I-ALU, Branch, Load, Store, JAL.

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/rv32i_format_enc.sv | 66 ++++++
 rtl/rv32i_instr_encoder.sv | 106 ++++++++++
 tb/tb_rv32i_instr_encoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcodes, instruction classes and encoder states
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I_ALU  = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_JAL    = 3'd5
    } instr_class_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } enc_state_e;

endpackage

// File: rtl/rv32i_format_enc.sv
// rtl/rv32i_format_enc.sv - combinational RV32I field packing and immediate range check
module rv32i_format_enc
    import rv32i_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        bad
);

    instr_class_e cls_e;
    logic         is_shift;
    logic         imm12_ok;
    logic         imm13_ok;

    assign cls_e    = instr_class_e'(cls);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // Sign-extension check: every bit above the field's sign bit equals the sign bit.
    assign imm12_ok = (&imm[20:11]) || !(|imm[20:11]);
    assign imm13_ok = (&imm[20:12]) || !(|imm[20:12]);

    // Pack fields per class; unknown classes flag bad and emit zero.
    always_comb begin
        word = 32'd0;
        bad  = 1'b0;
        case (cls_e)
            CLS_R: begin
                word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
            end
            CLS_I_ALU: begin
                if (is_shift) begin
                    word = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
                    bad  = |imm[20:5];
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OP_IMM};
                    bad  = !imm12_ok;
                end
            end
            CLS_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                bad  = !imm12_ok;
            end
            CLS_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                bad  = !imm12_ok;
            end
            CLS_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                bad  = !imm13_ok || imm[0];
            end
            CLS_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                bad  = imm[0];
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - encodes instruction fields and streams words into imem
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [20:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    input  logic              clear,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    enc_state_e  state;
    enc_state_e  state_next;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic        accept;
    logic        do_clear;
    logic        ack_now;

    rv32i_format_enc u_format_enc (
        .cls    (in_class),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .alt    (in_alt),
        .imm    (in_imm),
        .word   (enc_word),
        .bad    (enc_bad)
    );

    // Handshake qualifiers and next-state; clear outranks a new instruction.
    always_comb begin
        state_next = state;
        in_ready   = (state == ST_IDLE) && !full && !clear && !reset;
        accept     = in_valid && in_ready;
        do_clear   = (state == ST_IDLE) && clear;
        ack_now    = (state == ST_WRITE) && imem_ack;
        case (state)
            ST_IDLE:  if (accept && !enc_bad) state_next = ST_WRITE;
            ST_WRITE: if (imem_ack) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Write port, error pulse, pointer and fill tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
            err        <= 1'b0;
            full       <= 1'b0;
            count      <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                if (enc_bad) begin
                    err <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_wdata <= enc_word;
                end
            end
            if (do_clear) begin
                imem_addr <= BASE;
                count     <= '0;
                full      <= 1'b0;
            end
            if (ack_now) begin
                imem_we   <= 1'b0;
                imem_addr <= imem_addr + 1'b1;
                count     <= count + 1'b1;
                full      <= ((count + 1'b1) == DEPTH_CNT);
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - directed self-checking bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [20:0] in_imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic        clear;
    logic        err;
    logic        full;
    logic [8:0]  count;

    int checks = 0;
    int errors = 0;

    rv32i_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_alt     (in_alt),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .clear      (clear),
        .err        (err),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [20:0] imm);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_alt = alt; in_imm = imm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_expect(input string tag, input logic [31:0] word, input logic [7:0] addr,
                                input logic [8:0] cnt, input int hold);
        int n = 0;
        while (!imem_we && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_we"}, imem_we, 1);
        check({tag, "_wdata"}, imem_wdata, word);
        check({tag, "_addr"}, imem_addr, addr);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_we"}, imem_we, 1);
            check({tag, "_hold_wdata"}, imem_wdata, word);
            check({tag, "_hold_addr"}, imem_addr, addr);
            check({tag, "_hold_count"}, count, cnt - 9'd1);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check({tag, "_we_drop"}, imem_we, 0);
        check({tag, "_count"}, count, cnt);
        check({tag, "_addr_inc"}, imem_addr, addr + 8'd1);
    endtask

    task automatic expect_err(input string tag, input logic [7:0] addr, input logic [8:0] cnt);
        check({tag, "_err"}, err, 1);
        check({tag, "_no_we"}, imem_we, 0);
        tick();
        check({tag, "_err_pulse"}, err, 0);
        check({tag, "_no_we2"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_count"}, count, cnt);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_class = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_funct3 = 3'd0; in_alt = 1'b0; in_imm = 21'd0;
        imem_ack = 1'b0; clear = 1'b0;
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", in_ready, 1);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);

        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
        write_expect("add", 32'h002081B3, 8'd0, 9'd1, 0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0);
        write_expect("sub", 32'h402081B3, 8'd1, 9'd2, 0);
        send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFF);
        write_expect("addi_m1", 32'hFFF00293, 8'd2, 9'd3, 0);
        send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048);
        expect_err("addi_2048", 8'd3, 9'd3);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 21'd8);
        write_expect("sw", 32'h0020A423, 8'd3, 9'd4, 0);
        send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1FFFFC);
        write_expect("beq_m4", 32'hFE208EE3, 8'd4, 9'd5, 0);
        send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3);
        expect_err("beq_odd", 8'd5, 9'd5);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8);
        write_expect("jal", 32'h008000EF, 8'd5, 9'd6, 3);
        send(3'd1, 5'd6, 5'd7, 5'd0, 3'd5, 1'b1, 21'd4);
        write_expect("srai", 32'h4043D313, 8'd6, 9'd7, 0);
        send(3'd1, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 21'd32);
        expect_err("slli_32", 8'd7, 9'd7);

        // Clear during WRITE must be ignored.
        send(3'd3, 5'd4, 5'd3, 5'd0, 3'd2, 1'b0, 21'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_in_write_addr", imem_addr, 7);
        check("clr_in_write_count", count, 7);
        write_expect("lw", 32'h0041A203, 8'd7, 9'd8, 0);
        check("full_set", full, 1);
        check("full_ready", in_ready, 0);

        // Requests while full are dropped silently.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_we", imem_we, 0);
            check("full_no_err", err, 0);
            check("full_count", count, 8);
        end

        // Clear with in_valid: clear wins, nothing accepted.
        clear = 1'b1;
        #1;
        check("clr_ready", in_ready, 0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_addr", imem_addr, 0);
        check("clr_count", count, 0);
        check("clr_full", full, 0);
        tick();
        check("clr_no_we", imem_we, 0);
        check("clr_ready_back", in_ready, 1);

        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0);
        expect_err("class6", 8'd0, 9'd0);

        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
        write_expect("add2", 32'h002081B3, 8'd0, 9'd1, 0);

        // Reset in the middle of a pending write discards it.
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0);
        check("mid_we", imem_we, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_wdata", imem_wdata, 0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("stray_ack_count", count, 0);
        check("stray_ack_addr", imem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
